// File: rtl/mem_addr_seq_pkg.sv
// Shared definitions for the memory-address sequencer: source-select codes,
// FSM state encoding and the default exception-vector base address.
package mem_defs;

  localparam logic [1:0] MEM_SEL_PC   = 2'b00;
  localparam logic [1:0] MEM_SEL_B    = 2'b01;
  localparam logic [1:0] MEM_SEL_ALU  = 2'b10;
  localparam logic [1:0] MEM_SEL_HOLD = 2'b11;

  localparam int VEC_BASE_DEF = 253;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_addr_seq_src_mux.sv
// Combinational source select for the normal-mode memory address.
// The hold code is resolved in the top by not loading, so it simply maps to PC here.
module mem_src_mux
  import mem_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] regb_in,
  input  logic [DATA_W-1:0] aluout_in,
  output logic [DATA_W-1:0] data_out
);

  always_comb begin
    data_out = pc_in;
    case (sel)
      MEM_SEL_B:   data_out = regb_in;
      MEM_SEL_ALU: data_out = aluout_in;
      default:     data_out = pc_in;
    endcase
  end

endmodule

// File: rtl/mem_addr_seq.sv
// Registered memory-address unit: normal address loads from PC/regB/ALUOut, and an
// exception path that fetches a handler byte from the vector table and returns it as vec_pc.
//
// state   | meaning
// IDLE    | accepts normal loads and exceptions
// FETCH   | mem_rd high, waiting MEM_LAT cycles for the vector byte
// CAPTURE | samples mem_rdata, pulses vec_valid on exit
module mem_addr_seq
  import mem_defs::*;
#(
  parameter int DATA_W   = 32,
  parameter int VEC_BASE = VEC_BASE_DEF,
  parameter int N_VEC    = 3,
  parameter int MEM_LAT  = 1,
  parameter int CODE_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] regb_in,
  input  logic [DATA_W-1:0] aluout_in,
  input  logic              req_valid,
  input  logic              exc_valid,
  input  logic [CODE_W-1:0] exc_code,
  output logic              exc_ready,
  input  logic [7:0]        mem_rdata,
  output logic [DATA_W-1:0] addr_out,
  output logic              mem_rd,
  output logic              busy,
  output logic              vec_valid,
  output logic [DATA_W-1:0] vec_pc
);

  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_d, vec_pc_d, mux_out, vec_addr;
  logic              mem_rd_d, vec_valid_d;
  logic [CODE_W-1:0] idx;

  mem_src_mux #(.DATA_W(DATA_W)) u_src_mux (
    .sel       (sel),
    .pc_in     (pc_in),
    .regb_in   (regb_in),
    .aluout_in (aluout_in),
    .data_out  (mux_out)
  );

  // Extra bit on the compare so N_VEC == 2**CODE_W is still representable.
  always_comb begin
    idx = CODE_W'(N_VEC - 1);
    if ({1'b0, exc_code} < (CODE_W + 1)'(N_VEC)) idx = exc_code;
  end

  assign vec_addr  = DATA_W'(VEC_BASE) + DATA_W'(idx);
  assign busy      = (state_q != IDLE);
  assign exc_ready = (state_q == IDLE) && reset;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_out;
    mem_rd_d    = mem_rd;
    vec_valid_d = 1'b0;
    vec_pc_d    = vec_pc;
    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          addr_d   = vec_addr;
          mem_rd_d = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = FETCH;
        end else if (req_valid && (sel != MEM_SEL_HOLD)) begin
          addr_d = mux_out;
        end
      end
      FETCH: begin
        if (cnt_q == 2'd0) begin
          mem_rd_d = 1'b0;
          state_d  = CAPTURE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      CAPTURE: begin
        vec_pc_d    = DATA_W'(mem_rdata);
        vec_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      addr_out  <= '0;
      mem_rd    <= 1'b0;
      vec_valid <= 1'b0;
      vec_pc    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_out  <= addr_d;
      mem_rd    <= mem_rd_d;
      vec_valid <= vec_valid_d;
      vec_pc    <= vec_pc_d;
    end
  end

endmodule

// File: tb/tb_mem_addr_seq.sv
// Directed bench for mem_addr_seq: MEM_LAT=1 and MEM_LAT=3 instances, vec_pc
// results checked by a queue-based monitor including the arrival cycle.
module tb_mem_addr_seq;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic [31:0] pc_in, regb_in, aluout_in;
  logic        req_valid, exc_valid, exc_valid3, req3;
  logic [2:0]  exc_code, exc_code3;
  logic        exc_ready, exc_ready3;
  logic [7:0]  mem_rdata, mem_rdata3;
  logic [31:0] addr_out, addr_out3, vec_pc, vec_pc3;
  logic        mem_rd, mem_rd3, busy, busy3, vec_valid, vec_valid3;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   rd_cnt;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd253: return 8'h11;
      32'd254: return 8'h8C;
      32'd255: return 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  always_comb mem_rdata  = mem_byte(addr_out);
  always_comb mem_rdata3 = mem_byte(addr_out3);

  mem_addr_seq #(.MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .sel(sel), .pc_in(pc_in), .regb_in(regb_in),
    .aluout_in(aluout_in), .req_valid(req_valid), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_ready(exc_ready), .mem_rdata(mem_rdata),
    .addr_out(addr_out), .mem_rd(mem_rd), .busy(busy), .vec_valid(vec_valid),
    .vec_pc(vec_pc)
  );

  mem_addr_seq #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .sel(sel), .pc_in(pc_in), .regb_in(regb_in),
    .aluout_in(aluout_in), .req_valid(req3), .exc_valid(exc_valid3),
    .exc_code(exc_code3), .exc_ready(exc_ready3), .mem_rdata(mem_rdata3),
    .addr_out(addr_out3), .mem_rd(mem_rd3), .busy(busy3), .vec_valid(vec_valid3),
    .vec_pc(vec_pc3)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: every vec_valid pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (vec_valid) begin
      if (q1.size() == 0) check("vec_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("vec_pc", vec_pc, e.pc);
        check("vec_cycle", cyc, e.cyc);
      end
    end
    if (vec_valid3) begin
      if (q3.size() == 0) check("vec3_unexpected", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        check("vec3_pc", vec_pc3, e.pc);
        check("vec3_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; sel = 2'b00; pc_in = 32'h40; regb_in = 32'h0; aluout_in = 32'h0;
    req_valid = 1'b0; exc_valid = 1'b0; exc_code = 3'd0;
    exc_valid3 = 1'b0; exc_code3 = 3'd0; req3 = 1'b0;
    repeat (3) tick();
    check("rst_addr", addr_out, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, exc_ready}, 32'd0);
    check("rst_vec_pc", vec_pc, 32'h0);
    reset = 1'b1;
    #1 check("ready_after_rst", {31'b0, exc_ready}, 32'd1);

    // Normal loads
    sel = 2'b00; req_valid = 1'b1;
    tick(); check("load_pc", addr_out, 32'h40);
    sel = 2'b10; aluout_in = 32'h1234;
    tick(); check("load_alu", addr_out, 32'h1234);
    sel = 2'b11; pc_in = 32'h99;
    tick(); check("sel_hold", addr_out, 32'h1234);
    sel = 2'b00; req_valid = 1'b0;
    tick(); check("no_req_hold", addr_out, 32'h1234);

    // Vector fetch, code 1
    exc_valid = 1'b1; exc_code = 3'd1;
    tick();
    check("fetch_addr", addr_out, 32'd254);
    check("fetch_rd", {31'b0, mem_rd}, 32'd1);
    check("fetch_busy", {31'b0, busy}, 32'd1);
    check("fetch_ready", {31'b0, exc_ready}, 32'd0);
    q1.push_back('{32'h8C, cyc + 2});
    exc_code = 3'd0; sel = 2'b01; regb_in = 32'hBEEF; req_valid = 1'b1;
    tick();
    check("capture_addr", addr_out, 32'd254);
    check("capture_rd", {31'b0, mem_rd}, 32'd0);
    check("capture_busy", {31'b0, busy}, 32'd1);
    tick();
    check("done_busy", {31'b0, busy}, 32'd0);
    check("req_ignored", addr_out, 32'd254);
    exc_valid = 1'b0; req_valid = 1'b0;
    tick();
    check("no_second_fetch", {31'b0, busy}, 32'd0);

    // Priority over req_valid
    exc_valid = 1'b1; exc_code = 3'd0; req_valid = 1'b1; sel = 2'b00; pc_in = 32'h40;
    tick();
    check("prio_addr", addr_out, 32'd253);
    q1.push_back('{32'h11, cyc + 2});
    exc_valid = 1'b0; req_valid = 1'b0;
    repeat (2) tick();

    // Clamp out-of-range code
    exc_valid = 1'b1; exc_code = 3'd6;
    tick();
    check("clamp_addr", addr_out, 32'd255);
    q1.push_back('{32'h5A, cyc + 2});
    exc_valid = 1'b0;
    repeat (2) tick();

    // Held exc_valid restarts every 3 cycles
    exc_valid = 1'b1; exc_code = 3'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("b2b_busy", {31'b0, busy}, 32'd1);
      check("b2b_addr", addr_out, 32'd255);
      q1.push_back('{32'h5A, cyc + 2});
      repeat (2) tick();
    end
    exc_valid = 1'b0;
    tick();

    // MEM_LAT=3 instance
    exc_valid3 = 1'b1; exc_code3 = 3'd1;
    tick();
    check("lat3_addr", addr_out3, 32'd254);
    q3.push_back('{32'h8C, cyc + 4});
    exc_valid3 = 1'b0;
    rd_cnt = mem_rd3 ? 1 : 0;
    repeat (6) begin
      tick();
      if (mem_rd3) rd_cnt++;
    end
    check("lat3_rd_cycles", rd_cnt, 32'd3);

    // Reset during FETCH
    exc_valid = 1'b1; exc_code = 3'd0;
    tick();
    exc_valid = 1'b0;
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_addr", addr_out, 32'h0);
    check("async_rd", {31'b0, mem_rd}, 32'd0);
    check("async_busy", {31'b0, busy}, 32'd0);
    check("async_vec_pc", vec_pc, 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_vec_pc", vec_pc, 32'h0);
    check("post_rst_ready", {31'b0, exc_ready}, 32'd1);

    check("q1_drained", q1.size(), 32'd0);
    check("q3_drained", q3.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
